// File: rtl/x_countdown_8_bit_pkg.sv
// Shared constants and state encoding for the loadable 8-bit down-counter.
package x_countdown_8_bit_pkg;

  localparam int COUNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [COUNT_W-1:0] COUNT_ZERO = '0;
  localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);

  // Next state after loading a start value: a zero load skips RUN entirely.
  function automatic state_t load_state(input logic [COUNT_W-1:0] value);
    return (value != COUNT_ZERO) ? RUN : DONE;
  endfunction

endpackage

// File: rtl/x_countdown_8_bit.sv
// Loadable 8-bit down-counter / interval timer with per-bit pins.
// Optional auto-reload when X_COUNTDOWN_8_BIT_RELOAD_EN is defined: DONE
// reloads the last start value and keeps running until aborted or reset.
module x_countdown_8_bit
  import x_countdown_8_bit_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_halt,
  input  logic i_abort,
  input  logic i_value_7,
  input  logic i_value_6,
  input  logic i_value_5,
  input  logic i_value_4,
  input  logic i_value_3,
  input  logic i_value_2,
  input  logic i_value_1,
  input  logic i_value_0,
  output logic o_count_7,
  output logic o_count_6,
  output logic o_count_5,
  output logic o_count_4,
  output logic o_count_3,
  output logic o_count_2,
  output logic o_count_1,
  output logic o_count_0,
  output logic o_busy,
  output logic o_done
);

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] value;

`ifdef X_COUNTDOWN_8_BIT_RELOAD_EN
  logic [COUNT_W-1:0] reload_q, reload_d;
`endif

  assign value = {i_value_7, i_value_6, i_value_5, i_value_4,
                  i_value_3, i_value_2, i_value_1, i_value_0};

  // Next-state and next-count: abort > start > halt > decrement.
  always_comb begin
    // NOTE: every target gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    count_d = count_q;
`ifdef X_COUNTDOWN_8_BIT_RELOAD_EN
    reload_d = reload_q;
`endif

    if (i_abort) begin
      // Abort clears the count but keeps the reload value for the next start.
      state_d = IDLE;
      count_d = COUNT_ZERO;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            count_d = value;
            state_d = load_state(value);
`ifdef X_COUNTDOWN_8_BIT_RELOAD_EN
            reload_d = value;
`endif
          end
        end

        RUN: begin
          // Start is ignored while running; halt freezes the count.
          if (!i_halt) begin
            if (count_q <= COUNT_ONE) begin
              // Reaching zero and entering DONE happen on the same edge, so
              // RUN never holds a zero count and the decrement cannot wrap.
              count_d = COUNT_ZERO;
              state_d = DONE;
            end else begin
              count_d = count_q - COUNT_ONE;
            end
          end
        end

        DONE: begin
          if (i_start) begin
            // Restart straight from DONE with no dead cycle.
            count_d = value;
            state_d = load_state(value);
`ifdef X_COUNTDOWN_8_BIT_RELOAD_EN
            reload_d = value;
`endif
          end else begin
`ifdef X_COUNTDOWN_8_BIT_RELOAD_EN
            // Free-running period of reload+1 cycles; reload of zero parks
            // the counter in DONE with the done flag held high.
            count_d = reload_q;
            state_d = load_state(reload_q);
`else
            count_d = COUNT_ZERO;
            state_d = IDLE;
`endif
          end
        end

        default: begin
          state_d = IDLE;
          count_d = COUNT_ZERO;
        end
      endcase
    end
  end

  // State, count and reload registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      count_q  <= COUNT_ZERO;
`ifdef X_COUNTDOWN_8_BIT_RELOAD_EN
      reload_q <= COUNT_ZERO;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      count_q  <= count_d;
`ifdef X_COUNTDOWN_8_BIT_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  // Outputs are register bits or state decodes; no input reaches them
  // combinationally.
  assign {o_count_7, o_count_6, o_count_5, o_count_4,
          o_count_3, o_count_2, o_count_1, o_count_0} = count_q;
  assign o_busy = (state_q == RUN);
  assign o_done = (state_q == DONE);

endmodule

// File: tb/tb_x_countdown_8_bit.sv
// Directed self-checking bench for x_countdown_8_bit. Reload checks are
// compiled only when X_COUNTDOWN_8_BIT_RELOAD_EN is defined.
module tb_x_countdown_8_bit;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_start;
  logic       i_halt;
  logic       i_abort;
  logic [7:0] value;
  logic [7:0] count;
  logic       o_busy;
  logic       o_done;

  int assert_cnt;
  int fail_cnt;

  x_countdown_8_bit dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .i_halt    (i_halt),
    .i_abort   (i_abort),
    .i_value_7 (value[7]),
    .i_value_6 (value[6]),
    .i_value_5 (value[5]),
    .i_value_4 (value[4]),
    .i_value_3 (value[3]),
    .i_value_2 (value[2]),
    .i_value_1 (value[1]),
    .i_value_0 (value[0]),
    .o_count_7 (count[7]),
    .o_count_6 (count[6]),
    .o_count_5 (count[5]),
    .o_count_4 (count[4]),
    .o_count_3 (count[3]),
    .o_count_2 (count[2]),
    .o_count_1 (count[1]),
    .o_count_0 (count[0]),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] c, input logic b, input logic d);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".busy"}, 32'(o_busy), 32'(b));
    check({tag, ".done"}, 32'(o_done), 32'(d));
  endtask

  task automatic start_with(input logic [7:0] v);
    value   = v;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Watchdog: the stimulus is fixed-length, so this only fires on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int done_seen;

  initial begin
    assert_cnt = 0;
    fail_cnt   = 0;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_halt  = 1'b0;
    i_abort = 1'b0;
    value   = 8'd0;
    #12;
    expect_out("reset", 8'd0, 1'b0, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    expect_out("idle", 8'd0, 1'b0, 1'b0);

    // Value 3: counts 3,2,1 busy, then 0 with done for one cycle.
    start_with(8'd3);
    expect_out("v3.e0", 8'd3, 1'b1, 1'b0);
    tick(); expect_out("v3.e1", 8'd2, 1'b1, 1'b0);
    tick(); expect_out("v3.e2", 8'd1, 1'b1, 1'b0);
    tick(); expect_out("v3.e3", 8'd0, 1'b0, 1'b1);
    tick(); expect_out("v3.e4", 8'd0, 1'b0, 1'b0);

    // Value 0: done right after the start edge, never busy.
    start_with(8'd0);
    expect_out("v0.e0", 8'd0, 1'b0, 1'b1);
    tick(); expect_out("v0.e1", 8'd0, 1'b0, 1'b0);

    // Value 4 with a start pulse during RUN (ignored) and 2 halted cycles at 2.
    start_with(8'd4);
    expect_out("v4.e0", 8'd4, 1'b1, 1'b0);
    value = 8'd9; i_start = 1'b1;
    tick(); i_start = 1'b0;
    expect_out("v4.ign", 8'd3, 1'b1, 1'b0);
    tick(); expect_out("v4.e2", 8'd2, 1'b1, 1'b0);
    i_halt = 1'b1;
    tick(2);
    i_halt = 1'b0;
    expect_out("v4.halt", 8'd2, 1'b1, 1'b0);
    tick(); expect_out("v4.e5", 8'd1, 1'b1, 1'b0);
    tick(); expect_out("v4.e6", 8'd0, 1'b0, 1'b1);
    tick(); expect_out("v4.e7", 8'd0, 1'b0, 1'b0);

    // Restart from DONE with no dead cycle.
    start_with(8'd1);
    expect_out("rs.e0", 8'd1, 1'b1, 1'b0);
    tick(); expect_out("rs.done", 8'd0, 1'b0, 1'b1);
    start_with(8'd3);
    expect_out("rs.again", 8'd3, 1'b1, 1'b0);
    tick(3);
    expect_out("rs.done2", 8'd0, 1'b0, 1'b1);
    tick();

    // Value 255: done exactly at E0+255.
    start_with(8'd255);
    tick(254);
    expect_out("v255.e254", 8'd1, 1'b1, 1'b0);
    tick(); expect_out("v255.e255", 8'd0, 1'b0, 1'b1);
    tick(); expect_out("v255.idle", 8'd0, 1'b0, 1'b0);

    // Value 255 aborted at count 100: back to IDLE, no done.
    start_with(8'd255);
    tick(155);
    expect_out("ab.c100", 8'd100, 1'b1, 1'b0);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    expect_out("ab.idle", 8'd0, 1'b0, 1'b0);
    tick(3);
    expect_out("ab.quiet", 8'd0, 1'b0, 1'b0);

    // Abort beats start in the same cycle.
    value = 8'd7; i_start = 1'b1; i_abort = 1'b1;
    tick();
    i_start = 1'b0; i_abort = 1'b0;
    expect_out("ab.prio", 8'd0, 1'b0, 1'b0);

    // Reset mid-RUN at count 5: immediate clear, no done pulse afterwards.
    start_with(8'd8);
    tick(3);
    expect_out("rst.c5", 8'd5, 1'b1, 1'b0);
    #2 i_rst_n = 1'b0;
    #1 expect_out("rst.now", 8'd0, 1'b0, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_done) done_seen++;
    end
    check("rst.nodone", 32'(done_seen), 32'd0);

`ifdef X_COUNTDOWN_8_BIT_RELOAD_EN
    // Auto-reload with 2: done every 3 cycles, for 4 periods.
    start_with(8'd2);
    expect_out("rl.e0", 8'd2, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick(); expect_out($sformatf("rl.done%0d", k), 8'd0, 1'b0, 1'b1);
      tick(); expect_out($sformatf("rl.load%0d", k), 8'd2, 1'b1, 1'b0);
      tick(); expect_out($sformatf("rl.one%0d", k), 8'd1, 1'b1, 1'b0);
    end
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    expect_out("rl.abort", 8'd0, 1'b0, 1'b0);
    tick(4);
    expect_out("rl.stopped", 8'd0, 1'b0, 1'b0);

    // Start in DONE with 5 replaces the reload value.
    start_with(8'd1);
    tick(); expect_out("rl.d1", 8'd0, 1'b0, 1'b1);
    start_with(8'd5);
    expect_out("rl.v5", 8'd5, 1'b1, 1'b0);
    tick(5); expect_out("rl.v5done", 8'd0, 1'b0, 1'b1);
    tick(); expect_out("rl.v5reload", 8'd5, 1'b1, 1'b0);

    // Reload 0 holds done high until abort.
    start_with(8'd0);
    tick(3);
    expect_out("rl.zero", 8'd0, 1'b0, 1'b1);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    expect_out("rl.zabort", 8'd0, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/x_countdown_8_bit.md
# x_countdown_8_bit

Loadable 8-bit down-counter and timer. Takes a start value on eight discrete input pins, counts it down to zero, then pulses a done flag. It is the consuming counterpart of the free-running 8-bit up-counter, and is used to time intervals in board-level designs. It sits alongside the up-counter in the discrete-logic IP set and exposes per-bit pins so that each bit maps to a net.

## Interface
Parameters: none. Width is fixed at 8 through the package constant.

Ports:
- i_clk  input  1  single clock; all state changes on the rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_start  input  1  load i_value_* and begin; honoured only in IDLE or DONE
- i_halt  input  1  freeze count while in RUN
- i_abort  input  1  synchronous return to IDLE with count cleared; highest priority
- i_value_7 … i_value_0  input  1 each  start value, bit 7 = MSB
- o_count_7 … o_count_0  output  1 each  current count register, bit 7 = MSB
- o_busy  output  1  high while state is RUN
- o_done  output  1  high for exactly the cycles that state is DONE

## Operation
- States: IDLE, RUN, DONE.
- Reset (async assert) values:
  - state = IDLE, count = 0, reload register = 0
  - o_busy = 0, o_done = 0, all o_count_* = 0
- Priority on each edge: i_abort > i_start > i_halt > decrement.
- IDLE:
  - i_start=1: count ← value; reload ← value.
  - Next state is RUN if value≠0, otherwise DONE.
  - Else count holds.
- RUN:
  - i_halt=1: count holds.
  - Else count ← count−1.
  - If count==1 and not halted: count ← 0 and state ← DONE on the same edge.
  - i_start is ignored.
- DONE:
  - o_done=1.
  - i_start=1 behaves exactly as in IDLE (restart with no dead cycle).
  - Otherwise: next state IDLE, count holds at 0 (reload option changes this; see Configuration).
- i_abort=1 in any state: state ← IDLE, count ← 0, reload register unchanged.
- Arithmetic:
  - Unsigned 8-bit.
  - Decrement never wraps, because RUN never holds count 0.
  - Value 255 is legal.
- Deasserting i_rst_n mid-count: immediate return to reset values, with no done pulse.

## Timing
- i_start sampled at edge E0 with value N>0:
  - o_count = N after E0; o_count = N−k after E0+k (no halts).
  - o_busy high from after E0 through after E0+N−1.
  - o_count = 0 and o_done = 1 after E0+N, for one cycle.
- N=0: o_done = 1 after E0, o_busy never asserts.
- Each halted cycle delays done by one cycle.
- Outputs are registers or state decodes: no combinational path from inputs to outputs.

## Configuration
- Macro X_COUNTDOWN_8_BIT_RELOAD_EN.
- Defined (auto-reload):
  - In DONE with no i_start/i_abort: count ← reload register, and state ← RUN (reload≠0) or DONE (reload=0).
  - Period is N+1 cycles, with o_done pulsing once per period.
  - Reload=0 holds o_done high continuously.
  - Only i_abort or reset stops it.
- Undefined: DONE always exits to IDLE as described above, and the reload register may be omitted.

## Structure
- Package x_countdown_8_bit_pkg holds:
  - localparam COUNT_W = 8
  - typedef enum logic [1:0] state_t {IDLE, RUN, DONE}
- Single flat module with no sub-module. Next-state logic lives in one always_comb, and the state/count registers in one always_ff with async reset.

## Test plan
- Reset asserted mid-RUN with count=5 → all o_count_*=0, o_busy=0, o_done=0 immediately; no done pulse follows.
- Start with value 3 → o_count 3,2,1,0 on successive cycles; o_busy high for 3 cycles; o_done high for exactly 1 cycle at count 0.
- Start with value 0 → o_done high the cycle after start; o_busy stays 0.
- Value 4, i_halt held for 2 cycles at count 2 → done arrives 2 cycles late (E0+6); i_start pulsed during RUN is ignored.
- Value 255 → done at E0+255; i_abort at count 100 → IDLE, count 0, no done.
- RELOAD_EN, value 2 → o_done pulses every 3 cycles for ≥4 periods; i_abort stops it; i_start in DONE with value 5 reloads 5.
